ip_rx_decoder: RTL and testbench

Receive-side IPv4 stage that sits directly upstream of the TCP decoder. It accepts an IPv4 packet as a byte stream with a valid/ready handshake and assembles it into a flat TCP segment register. It validates the IPv4 header, including an incremental header checksum. For each good packet it delivers the TCP header plus payload, with the first byte in the MSBs, together with a one-cycle `ip_decode_valid` pulse. Bad packets are counted and discarded.

---
 rtl/ip_rx_decoder_pkg.sv | 27 ++
 rtl/ip_rx_decoder_csum_acc.sv | 25 ++
 rtl/ip_rx_decoder.sv | 180 ++++++++++++++++++
 tb/tb_ip_rx_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ip_rx_decoder_pkg.sv
// Shared IPv4 receive constants, FSM encoding and the ones-complement adder
// used by the IP decoder, TCP decoder and TX path.
package ip_rx_decoder_pkg;

   localparam logic [3:0]  IP_VERSION   = 4'd4;
   localparam logic [7:0]  IP_PROTO_TCP = 8'd6;
   localparam logic [15:0] IP_MF_MASK   = 16'h2000;
   localparam logic [15:0] IP_OFF_MASK  = 16'h1FFF;

   typedef enum logic [1:0] {
      ST_RECV    = 2'd0,
      ST_CHECK   = 2'd1,
      ST_DISCARD = 2'd2
   } rx_state_t;

   function automatic int frame_len(input int iph_len, input int tcph_len, input int payload_len);
      return iph_len + tcph_len + payload_len;
   endfunction

   // Largest 17-bit sum is 1FFFE, so folding the carry back in cannot overflow again.
   function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/ip_rx_decoder_csum_acc.sv
// 16-bit ones-complement accumulator for the IPv4 header checksum.
module ip_csum_acc
   import ip_rx_decoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        add_en,
   input  logic [15:0] word,
   output logic [15:0] sum
);

   logic [15:0] r_sum;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_sum <= 16'd0;
      end else if (add_en) begin
         r_sum <= ones_add(r_sum, word);
      end
   end

   assign sum = r_sum;

endmodule

// File: rtl/ip_rx_decoder.sv
// IPv4 receive stage: validates a fixed-size IPv4/TCP frame byte stream and
// publishes the TCP header plus payload as one flat register on acceptance.
module ip_rx_decoder
   import ip_rx_decoder_pkg::*;
#(
   parameter int          PAYLOAD_LEN = 262,
   parameter int          TCPH_LEN    = 20,
   parameter int          IPH_LEN     = 20,
   parameter logic [7:0]  PROTOCOL    = IP_PROTO_TCP,
   parameter logic [31:0] DESADDR     = 32'h7f000001
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 rx_valid,
   input  logic [7:0]                           rx_data,
   input  logic                                 rx_last,
   output logic                                 rx_ready,
   output logic                                 ip_decode_valid,
   output logic [(PAYLOAD_LEN+TCPH_LEN)*8-1:0]  rx_tcp_data,
   output logic                                 ip_drop,
   output logic [15:0]                          drop_count
);

   localparam int FRAME_LEN = frame_len(IPH_LEN, TCPH_LEN, PAYLOAD_LEN);
   localparam int CNT_W     = $clog2(FRAME_LEN);
   localparam int SEG_W     = (PAYLOAD_LEN + TCPH_LEN) * 8;
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] HDR_END   = CNT_W'(IPH_LEN);
   localparam logic [3:0]       REQ_IHL   = 4'(IPH_LEN / 4);
   localparam logic [15:0]      REQ_TOTAL = 16'(FRAME_LEN);

   rx_state_t         r_state;
   rx_state_t         w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0]        r_prev_byte;
   logic [7:0]        r_ver_ihl;
   logic [15:0]       r_total_len;
   logic [15:0]       r_frag;
   logic [7:0]        r_proto;
   logic [31:0]       r_dst;
   logic              r_len_err;
   logic [SEG_W-1:0]  r_seg;
   logic [SEG_W-1:0]  r_tcp_data;
   logic              r_valid;
   logic              r_drop;
   logic [15:0]       r_drop_count;

   logic              w_ready;
   logic              w_xfer;
   logic              w_in_hdr;
   logic              w_at_last;
   logic              w_csum_en;
   logic              w_csum_clr;
   logic              w_set_err;
   logic              w_pkt_ok;
   logic [15:0]       w_csum;

   assign w_ready    = !rst && (r_state != ST_CHECK);
   assign w_xfer     = rx_valid && w_ready;
   assign w_in_hdr   = r_cnt < HDR_END;
   assign w_at_last  = r_cnt == LAST_IDX;
   assign w_csum_en  = w_xfer && (r_state == ST_RECV) && w_in_hdr && r_cnt[0];
   assign w_csum_clr = r_state == ST_CHECK;

   ip_csum_acc u_csum (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_csum_clr),
      .add_en (w_csum_en),
      .word   ({r_prev_byte, rx_data}),
      .sum    (w_csum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RECV;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_set_err    = 1'b0;
      case (r_state)
         ST_RECV: begin
            if (w_xfer) begin
               if (rx_last) begin
                  w_state_next = ST_CHECK;
                  w_set_err    = !w_at_last;
               end else if (w_at_last) begin
                  w_state_next = ST_DISCARD;
                  w_set_err    = 1'b1;
               end
            end
         end
         ST_DISCARD: begin
            if (w_xfer && rx_last) begin
               w_state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_state_next = ST_RECV;
         end
         default: begin
            w_state_next = ST_RECV;
         end
      endcase
   end

   // DF (bit 14) is deliberately left out of the fragment test.
   assign w_pkt_ok = !r_len_err
                  && (r_ver_ihl[7:4] == IP_VERSION)
                  && (r_ver_ihl[3:0] == REQ_IHL)
                  && (r_total_len == REQ_TOTAL)
                  && ((r_frag & (IP_MF_MASK | IP_OFF_MASK)) == 16'd0)
                  && (r_proto == PROTOCOL)
                  && (r_dst == DESADDR)
                  && (w_csum == 16'hFFFF);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_prev_byte  <= 8'd0;
         r_ver_ihl    <= 8'd0;
         r_total_len  <= 16'd0;
         r_frag       <= 16'd0;
         r_proto      <= 8'd0;
         r_dst        <= 32'd0;
         r_len_err    <= 1'b0;
         r_seg        <= '0;
         r_tcp_data   <= '0;
         r_valid      <= 1'b0;
         r_drop       <= 1'b0;
         r_drop_count <= 16'd0;
      end else begin
         r_valid <= 1'b0;
         r_drop  <= 1'b0;
         if (r_state == ST_CHECK) begin
            r_cnt     <= '0;
            r_len_err <= 1'b0;
            if (w_pkt_ok) begin
               r_tcp_data <= r_seg;
               r_valid    <= 1'b1;
            end else begin
               r_drop <= 1'b1;
               if (r_drop_count != 16'hFFFF) begin
                  r_drop_count <= r_drop_count + 16'd1;
               end
            end
         end
         if ((r_state == ST_RECV) && w_xfer) begin
            r_cnt       <= r_cnt + 1'b1;
            r_prev_byte <= rx_data;
            if (w_in_hdr) begin
               case (r_cnt)
                  CNT_W'(0): r_ver_ihl <= rx_data;
                  CNT_W'(2), CNT_W'(3): r_total_len <= {r_total_len[7:0], rx_data};
                  CNT_W'(6), CNT_W'(7): r_frag <= {r_frag[7:0], rx_data};
                  CNT_W'(9): r_proto <= rx_data;
                  CNT_W'(16), CNT_W'(17), CNT_W'(18), CNT_W'(19): r_dst <= {r_dst[23:0], rx_data};
                  default: ;
               endcase
            end else begin
               r_seg <= {r_seg[SEG_W-9:0], rx_data};
            end
         end
         if (w_set_err) begin
            r_len_err <= 1'b1;
         end
      end
   end

   assign rx_ready        = w_ready;
   assign ip_decode_valid = r_valid;
   assign rx_tcp_data     = r_tcp_data;
   assign ip_drop         = r_drop;
   assign drop_count      = r_drop_count;

endmodule

// File: tb/tb_ip_rx_decoder.sv
// Directed bench for ip_rx_decoder: good/bad headers, length errors, gaps,
// mid-packet reset and drop counter saturation.
module tb_ip_rx_decoder;

   localparam int SEG_BYTES = 282;
   localparam int SEG_W     = SEG_BYTES * 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             rx_last;
   logic             rx_ready;
   logic             ip_decode_valid;
   logic [SEG_W-1:0] rx_tcp_data;
   logic             ip_drop;
   logic [15:0]      drop_count;

   ip_rx_decoder dut (
      .clk             (clk),
      .rst             (rst),
      .rx_valid        (rx_valid),
      .rx_data         (rx_data),
      .rx_last         (rx_last),
      .rx_ready        (rx_ready),
      .ip_decode_valid (ip_decode_valid),
      .rx_tcp_data     (rx_tcp_data),
      .ip_drop         (ip_drop),
      .drop_count      (drop_count)
   );

   always #5 clk = ~clk;

   logic [7:0] good_hdr [0:19] = '{8'h45, 8'h00, 8'h01, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h06,
                                   8'h3B, 8'hC8, 8'h7F, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h00, 8'h00, 8'h01};
   logic [7:0]       pkt [0:511];
   logic [SEG_W-1:0] exp_seg;
   logic [SEG_W-1:0] last_good;
   int               checks = 0;
   int               errors = 0;
   int               n_valid = 0;
   int               n_drop = 0;
   logic             obs_v0, obs_v1, obs_v2, obs_d0, obs_d1, obs_d2, obs_rdy0;

   always @(negedge clk) begin
      if (ip_decode_valid) n_valid++;
      if (ip_drop) n_drop++;
   end

   function automatic int first_diff(input logic [SEG_W-1:0] a, input logic [SEG_W-1:0] b);
      for (int k = 0; k < SEG_BYTES; k++) begin
         if (a[SEG_W-1-8*k -: 8] !== b[SEG_W-1-8*k -: 8]) return k;
      end
      return -1;
   endfunction

   task automatic build_good(input int seed);
      for (int i = 0; i < 20; i++) pkt[i] = good_hdr[i];
      for (int k = 0; k < SEG_BYTES; k++) begin
         pkt[20+k] = (k == 0) ? 8'hA5 : 8'((k * 13 + seed * 7) & 255);
         exp_seg[SEG_W-1-8*k -: 8] = pkt[20+k];
      end
   endtask

   task automatic send_bytes(input int len, input bit gaps, input bit mark_last);
      int w;
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         rx_valid = 1'b1;
         rx_data  = pkt[i];
         rx_last  = mark_last && (i == len - 1);
         w = 0;
         while (!rx_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         checks++;
         if (!rx_ready) begin
            errors++;
            $display("FAIL ready_timeout: byte %0d rx_ready got 0 expected 1", i);
         end
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      rx_last  = 1'b0;
   endtask

   task automatic run_packet(input int len, input bit gaps);
      send_bytes(len, gaps, 1'b1);
      obs_v0 = ip_decode_valid; obs_d0 = ip_drop; obs_rdy0 = rx_ready;
      @(posedge clk); #1;
      obs_v1 = ip_decode_valid; obs_d1 = ip_drop;
      @(posedge clk); #1;
      obs_v2 = ip_decode_valid; obs_d2 = ip_drop;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rx_ready); end
      checks++; if (ip_decode_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ip_decode_valid); end
      checks++; if (ip_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", ip_drop); end
      checks++; if (drop_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", drop_count); end
      checks++; if (rx_tcp_data !== '0) begin errors++; $display("FAIL reset_data: first nonzero byte %0d", first_diff(rx_tcp_data, '0)); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", rx_ready); end
      last_good = '0;
   endtask

   task automatic test_good();
      build_good(1);
      run_packet(302, 1'b0);
      checks++; if (obs_rdy0 !== 1'b0) begin errors++; $display("FAIL good_check_ready: got %b expected 0", obs_rdy0); end
      checks++; if (obs_v0 !== 1'b0) begin errors++; $display("FAIL good_valid_early: got %b expected 0", obs_v0); end
      checks++; if (obs_v1 !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", obs_v1); end
      checks++; if (obs_v2 !== 1'b0) begin errors++; $display("FAIL good_valid_width: got %b expected 0", obs_v2); end
      checks++; if (obs_d1 !== 1'b0) begin errors++; $display("FAIL good_drop: got %b expected 0", obs_d1); end
      checks++; if (rx_tcp_data[2255:2248] !== 8'hA5) begin errors++; $display("FAIL good_byte0: got %h expected a5", rx_tcp_data[2255:2248]); end
      checks++; if (rx_tcp_data !== exp_seg) begin errors++; $display("FAIL good_data: byte %0d got %h expected %h", first_diff(rx_tcp_data, exp_seg), rx_tcp_data[SEG_W-1-8*first_diff(rx_tcp_data, exp_seg) -: 8], exp_seg[SEG_W-1-8*first_diff(rx_tcp_data, exp_seg) -: 8]); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL good_count: got %0d expected 0", drop_count); end
      last_good = exp_seg;
   endtask

   task automatic test_bad_header(input string name, input int idx_a, input logic [7:0] val_a,
                                  input int idx_b, input logic [7:0] val_b, input logic [15:0] exp_cnt);
      build_good(2);
      pkt[idx_a] = val_a;
      pkt[idx_b] = val_b;
      run_packet(302, 1'b0);
      checks++; if (obs_d1 !== 1'b1) begin errors++; $display("FAIL %s_drop: got %b expected 1", name, obs_d1); end
      checks++; if (obs_d2 !== 1'b0) begin errors++; $display("FAIL %s_drop_width: got %b expected 0", name, obs_d2); end
      checks++; if (obs_v1 !== 1'b0) begin errors++; $display("FAIL %s_valid: got %b expected 0", name, obs_v1); end
      checks++; if (drop_count !== exp_cnt) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, drop_count, exp_cnt); end
      checks++; if (rx_tcp_data !== last_good) begin errors++; $display("FAIL %s_data_held: byte %0d changed", name, first_diff(rx_tcp_data, last_good)); end
   endtask

   task automatic test_short();
      build_good(4);
      run_packet(101, 1'b0);
      checks++; if (obs_d1 !== 1'b1) begin errors++; $display("FAIL short_drop: got %b expected 1", obs_d1); end
      checks++; if (obs_rdy0 !== 1'b0) begin errors++; $display("FAIL short_check_ready: got %b expected 0", obs_rdy0); end
      checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL short_count: got %0d expected 4", drop_count); end
      build_good(5);
      run_packet(302, 1'b0);
      checks++; if (obs_v1 !== 1'b1) begin errors++; $display("FAIL after_short_valid: got %b expected 1", obs_v1); end
      checks++; if (rx_tcp_data !== exp_seg) begin errors++; $display("FAIL after_short_data: byte %0d differs", first_diff(rx_tcp_data, exp_seg)); end
      last_good = exp_seg;
   endtask

   task automatic test_long();
      int d0, v0;
      build_good(6);
      for (int i = 302; i < 310; i++) pkt[i] = 8'(i);
      d0 = n_drop; v0 = n_valid;
      run_packet(310, 1'b0);
      checks++; if (obs_d1 !== 1'b1) begin errors++; $display("FAIL long_drop: got %b expected 1", obs_d1); end
      checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL long_drop_pulses: got %0d expected 1", n_drop - d0); end
      checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL long_valid_pulses: got %0d expected 0", n_valid - v0); end
      checks++; if (drop_count !== 16'd5) begin errors++; $display("FAIL long_count: got %0d expected 5", drop_count); end
      checks++; if (rx_tcp_data !== last_good) begin errors++; $display("FAIL long_data_held: byte %0d changed", first_diff(rx_tcp_data, last_good)); end
   endtask

   task automatic test_gaps();
      build_good(1);
      run_packet(302, 1'b1);
      checks++; if (obs_v1 !== 1'b1 || obs_v2 !== 1'b0) begin errors++; $display("FAIL gaps_valid: got %b%b expected 10", obs_v1, obs_v2); end
      checks++; if (rx_tcp_data !== exp_seg) begin errors++; $display("FAIL gaps_data: byte %0d differs", first_diff(rx_tcp_data, exp_seg)); end
      checks++; if (drop_count !== 16'd5) begin errors++; $display("FAIL gaps_count: got %0d expected 5", drop_count); end
      last_good = exp_seg;
   endtask

   task automatic test_reset_mid();
      int d0, v0;
      build_good(7);
      d0 = n_drop; v0 = n_valid;
      send_bytes(150, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", rx_ready); end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (n_drop - d0 !== 0 || n_valid - v0 !== 0) begin errors++; $display("FAIL midrst_pulses: got drop %0d valid %0d expected 0 0", n_drop - d0, n_valid - v0); end
      checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", drop_count); end
      build_good(8);
      run_packet(302, 1'b0);
      checks++; if (obs_v1 !== 1'b1) begin errors++; $display("FAIL midrst_next_valid: got %b expected 1", obs_v1); end
      checks++; if (rx_tcp_data !== exp_seg) begin errors++; $display("FAIL midrst_next_data: byte %0d differs", first_diff(rx_tcp_data, exp_seg)); end
   endtask

   task automatic test_saturate();
      force dut.r_drop_count = 16'hFFFE;
      @(posedge clk); #1;
      release dut.r_drop_count;
      @(posedge clk); #1;
      pkt[0] = 8'h45;
      run_packet(1, 1'b0);
      checks++; if (obs_d1 !== 1'b1) begin errors++; $display("FAIL sat_drop1: got %b expected 1", obs_d1); end
      checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count1: got %h expected ffff", drop_count); end
      run_packet(1, 1'b0);
      checks++; if (obs_d1 !== 1'b1) begin errors++; $display("FAIL sat_drop2: got %b expected 1", obs_d1); end
      checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count2: got %h expected ffff", drop_count); end
   endtask

   initial begin
      test_reset();
      test_good();
      test_bad_header("csum", 11, 8'hC9, 11, 8'hC9, 16'd1);
      test_bad_header("proto", 9, 8'h11, 11, 8'hBD, 16'd2);
      test_bad_header("dest", 19, 8'h02, 11, 8'hC7, 16'd3);
      test_short();
      test_long();
      test_gaps();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
